// File: rtl/spi_master_interface_pkg.sv
// Shared constants, command/state encodings and frame payload type for the SPI master.
package spi_master_interface_pkg;

  localparam int unsigned ADDR_SIZE  = 8;
  localparam int unsigned CMD_W      = 2;
  localparam int unsigned FRAME_SIZE = CMD_W + ADDR_SIZE;
  localparam int unsigned HOLD_CYC   = 2;
  localparam int unsigned RD_LATENCY = 3;
  localparam int unsigned GAP_CYC    = 1;
  localparam int unsigned RX_BITS    = ADDR_SIZE;

  // Larger of two counts, used to size the shared bit counter.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CNT_MAX = max2(max2(FRAME_SIZE, RD_LATENCY),
                                         max2(max2(RX_BITS, HOLD_CYC), GAP_CYC));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_CMD,
    ST_SHIFT,
    ST_HOLD,
    ST_WAIT,
    ST_RECV,
    ST_GAP
  } state_e;

  // Bits shifted after the command-check bit, MSB first.
  typedef struct packed {
    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] payload;
  } frame_t;

endpackage

// File: rtl/spi_master_interface_if.sv
// Host handshake plus SPI pins of the master; master modport faces the DUT.
interface spi_master_interface_if;
  import spi_master_interface_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CMD_W-1:0]     cmd;
  logic [ADDR_SIZE-1:0] payload;
  logic                 rd_valid;
  logic [RX_BITS-1:0]   rd_data;
  logic                 seq_err;
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;

  modport master (
    input  cmd_valid, cmd, payload, MISO,
    output cmd_ready, rd_valid, rd_data, seq_err, SS_n, MOSI
  );

  modport slave (
    output cmd_valid, cmd, payload, MISO,
    input  cmd_ready, rd_valid, rd_data, seq_err, SS_n, MOSI
  );

endinterface

// File: rtl/spi_master_interface_bit_shifter.sv
// MOSI parallel-load shifter, MISO capture register and the shared down-counter.
module spi_master_interface_bit_shifter
  import spi_master_interface_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  frame_t             frame_i,
  input  logic               shift_i,
  input  logic               capture_i,
  input  logic               miso_i,
  input  logic               cnt_load_i,
  input  logic [CNT_W-1:0]   cnt_val_i,
  output logic               tx_msb_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [RX_BITS-1:0] rx_next_c
);

  logic [FRAME_SIZE-1:0] tx_q;
  logic [RX_BITS-2:0]    rx_q;
  logic [CNT_W-1:0]      cnt_q;

  // Transmit register: load on accept, shift left once per MOSI bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= '0;
    end else if (load_i) begin
      tx_q <= frame_i;
    end else if (shift_i) begin
      tx_q <= {tx_q[FRAME_SIZE-2:0], 1'b0};
    end
  end

  // Receive register keeps the first seven bits; the eighth comes straight from MISO.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q <= '0;
    end else if (capture_i) begin
      rx_q <= {rx_q[RX_BITS-3:0], miso_i};
    end
  end

  // Down-counter loaded with (cycles-1) on state entry; parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_load_i) begin
      cnt_q <= cnt_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tx_msb_o  = tx_q[FRAME_SIZE-1];
  assign cnt_o     = cnt_q;
  assign rx_next_c = {rx_q, miso_i};

endmodule

// File: rtl/spi_master_interface.sv
// SPI master: one host command per frame, MSB-first on MOSI, 8-bit read-back on MISO.
module spi_master_interface
  import spi_master_interface_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  spi_master_interface_if.master bus
);

  state_e             state_q, state_d;
  cmd_e               cmd_q, cmd_d;
  logic               rd_armed_q, rd_armed_d;
  logic               ss_n_q, ss_n_d;
  logic               mosi_q, mosi_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rd_valid_q, rd_valid_d;
  logic [RX_BITS-1:0] rd_data_q, rd_data_d;
  logic               seq_err_q, seq_err_d;

  logic               load_en;
  logic               shift_en;
  logic               capture_en;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               tx_msb;
  logic [CNT_W-1:0]   cnt;
  logic [RX_BITS-1:0] rx_next;
  logic               cnt_done;
  frame_t             acc_frame;

  assign acc_frame.cmd     = cmd_e'(bus.cmd);
  assign acc_frame.payload = bus.payload;
  assign cnt_done          = (cnt == '0);

  spi_master_interface_bit_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_en),
    .frame_i    (acc_frame),
    .shift_i    (shift_en),
    .capture_i  (capture_en),
    .miso_i     (bus.MISO),
    .cnt_load_i (cnt_load),
    .cnt_val_i  (cnt_val),
    .tx_msb_o   (tx_msb),
    .cnt_o      (cnt),
    .rx_next_c  (rx_next)
  );

  // State and registered outputs; outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_WR_ADDR;
      rd_armed_q  <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rd_armed_q  <= rd_armed_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      cmd_ready_q <= cmd_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      seq_err_q   <= seq_err_d;
    end
  end

  // Next-state, shifter control and next output values.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rd_armed_d  = rd_armed_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    seq_err_d   = 1'b0;
    load_en     = 1'b0;
    capture_en  = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d   = ST_SEL;
          load_en   = 1'b1;
          cmd_d     = cmd_e'(bus.cmd);
          seq_err_d = (cmd_e'(bus.cmd) == CMD_RD_DATA) && !rd_armed_q;
        end
      end
      ST_SEL: begin
        state_d = ST_CMD;
      end
      ST_CMD: begin
        state_d  = ST_SHIFT;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(FRAME_SIZE - 1);
      end
      ST_SHIFT: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          if (cmd_q == CMD_RD_DATA) begin
            state_d = ST_WAIT;
            cnt_val = CNT_W'(RD_LATENCY - 1);
          end else begin
            state_d = ST_HOLD;
            cnt_val = CNT_W'(HOLD_CYC - 1);
          end
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          state_d  = ST_GAP;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(GAP_CYC - 1);
          if (cmd_q == CMD_RD_ADDR) begin
            rd_armed_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_done) begin
          state_d  = ST_RECV;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(RX_BITS - 1);
        end
      end
      ST_RECV: begin
        capture_en = 1'b1;
        if (cnt_done) begin
          state_d    = ST_GAP;
          cnt_load   = 1'b1;
          cnt_val    = CNT_W'(GAP_CYC - 1);
          rd_data_d  = rx_next;
          rd_valid_d = 1'b1;
          rd_armed_d = 1'b0;
        end
      end
      ST_GAP: begin
        if (cnt_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ss_n_d      = (state_d == ST_IDLE) || (state_d == ST_GAP);
    cmd_ready_d = (state_d == ST_IDLE);
    shift_en    = (state_d == ST_SHIFT);
    mosi_d      = ((state_d == ST_CMD) || (state_d == ST_SHIFT)) ? tx_msb : 1'b0;
  end

  assign bus.SS_n      = ss_n_q;
  assign bus.MOSI      = mosi_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_spi_master_interface.sv
// Bench for spi_master_interface: behavioural slave+RAM on the pins, command-level scoreboard.
module tb_spi_master_interface;

  // Frame geometry from the block description, independent of the RTL package.
  localparam int WR_LEN  = 2 + 10 + 2;
  localparam int RD_LEN  = 2 + 10 + 3 + 8;
  localparam int GAP_EXP = 1;
  localparam int RECV_C0 = 2 + 10 + 3;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  spi_master_interface_if bus();

  spi_master_interface dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard state at command level.
  logic [7:0] exp_ram [256];
  logic [7:0] exp_waddr;
  logic [7:0] exp_raddr;
  logic [7:0] exp_rd_data;
  logic       armed;

  // Slave+RAM model state.
  logic [7:0] slave_ram [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave: decodes the 10-bit frame after SEL/CMD bits and returns RAM data for rd-data frames.
  initial begin : slave_model
    int         c;
    logic [9:0] fr;
    logic [7:0] s_waddr, s_raddr, rbyte;
    c = 0; fr = '0; s_waddr = '0; s_raddr = '0; rbyte = '0;
    for (int i = 0; i < 256; i++) slave_ram[i] = 8'h00;
    bus.MISO = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.SS_n) begin
        c = 0;
        bus.MISO = 1'b0;
      end else begin
        if (c >= 2 && c <= 11) fr = {fr[8:0], bus.MOSI};
        if (c == 11) begin
          case (fr[9:8])
            2'b00: s_waddr = fr[7:0];
            2'b01: slave_ram[s_waddr] = fr[7:0];
            2'b10: s_raddr = fr[7:0];
            default: rbyte = slave_ram[s_raddr];
          endcase
        end
        if (fr[9:8] == 2'b11 && c >= RECV_C0 && c < RECV_C0 + 8)
          bus.MISO = rbyte[3'(RECV_C0 + 7 - c)];
        else
          bus.MISO = 1'b0;
        c++;
      end
    end
  end

  // One host command: accept, observe the whole frame and gap, then update the scoreboard.
  task automatic xfer(input logic [1:0] c, input logic [7:0] p, input bit hold, input bit inject);
    int          n, len, gap, rv, se, exp_len;
    logic [31:0] bits, mask;
    logic [7:0]  got, exp_byte;
    logic [11:0] hdr;
    logic        exp_seq;
    bit          done;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(bus.cmd_ready), 32'd1);
    exp_len  = (c == 2'b11) ? RD_LEN : WR_LEN;
    exp_seq  = (c == 2'b11) && !armed;
    exp_byte = exp_ram[exp_raddr];
    bus.cmd = c; bus.payload = p; bus.cmd_valid = 1'b1;
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
    len = 0; gap = 0; rv = 0; se = 0; bits = '0; got = '0; done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (bus.cmd_ready === 1'b1) begin
        done = 1;
      end else begin
        if (bus.SS_n === 1'b0) begin
          len++;
          bits = {bits[30:0], bus.MOSI};
        end else begin
          gap++;
        end
        if (bus.rd_valid === 1'b1) begin rv++; got = bus.rd_data; end
        if (bus.seq_err === 1'b1) se++;
        if (inject) begin
          bus.cmd = 2'b01; bus.payload = 8'h77;
          bus.cmd_valid = (len == RECV_C0 + 2);
        end
        @(negedge clk);
      end
    end
    check("frame_end", 32'(done), 32'd1);
    check("ss_low_len", 32'(len), 32'(exp_len));
    hdr = 12'(bits >> (exp_len - 12));
    check("mosi_frame", 32'(hdr), 32'({1'b0, c[1], c, p}));
    if (c != 2'b11) begin
      mask = (32'd1 << (exp_len - 12)) - 32'd1;
      check("mosi_hold_zero", bits & mask, 32'd0);
    end
    check("gap_cycles", 32'(gap), 32'(GAP_EXP));
    check("seq_err_pulses", 32'(se), 32'(exp_seq));
    check("rd_valid_pulses", 32'(rv), (c == 2'b11) ? 32'd1 : 32'd0);
    case (c)
      2'b00: exp_waddr = p;
      2'b01: exp_ram[exp_waddr] = p;
      2'b10: begin exp_raddr = p; armed = 1'b1; end
      default: begin armed = 1'b0; exp_rd_data = exp_byte; end
    endcase
    if (c == 2'b11) check("rd_data_pulse", 32'(got), 32'(exp_byte));
    check("rd_data_hold", 32'(bus.rd_data), 32'(exp_rd_data));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lows;
    logic [1:0] rc;
    logic [7:0] rp;
    for (int i = 0; i < 256; i++) exp_ram[i] = 8'h00;
    exp_waddr = '0; exp_raddr = '0; exp_rd_data = '0; armed = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd = '0; bus.payload = '0;
    rst = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ss_n", 32'(bus.SS_n), 32'd1);
    check("rst_mosi", 32'(bus.MOSI), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_seq_err", 32'(bus.seq_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // rd-data with no preceding rd-addr.
    xfer(2'b11, 8'h00, 1'b0, 1'b0);

    // wr-addr 0x3C, wr-data 0xA5.
    xfer(2'b00, 8'h3C, 1'b0, 1'b0);
    xfer(2'b01, 8'hA5, 1'b0, 1'b0);
    check("ram_3c", 32'(slave_ram[8'h3C]), 32'(exp_ram[8'h3C]));

    // rd-addr 0x3C, rd-data.
    xfer(2'b10, 8'h3C, 1'b0, 1'b0);
    xfer(2'b11, 8'h00, 1'b0, 1'b0);

    // cmd_valid held high back-to-back.
    xfer(2'b00, 8'h10, 1'b1, 1'b0);
    xfer(2'b01, 8'h5A, 1'b1, 1'b0);
    xfer(2'b10, 8'h10, 1'b0, 1'b0);

    // cmd_valid pulse during RECV is dropped.
    xfer(2'b11, 8'h00, 1'b0, 1'b1);
    bus.cmd_valid = 1'b0;
    lows = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.SS_n !== 1'b1) lows++;
      @(negedge clk);
    end
    check("recv_pulse_ignored", 32'(lows), 32'd0);

    // Randomised command mix.
    for (int i = 0; i < 24; i++) begin
      rc = 2'($urandom_range(3, 0));
      rp = 8'($urandom);
      xfer(rc, rp, 1'($urandom_range(1, 0)), 1'b0);
    end
    bus.cmd_valid = 1'b0;
    for (int a = 0; a < 256; a += 37)
      check("ram_sweep", 32'(slave_ram[a]), 32'(exp_ram[a]));

    // Reset in the middle of a wr-data shift.
    xfer(2'b00, 8'h3C, 1'b0, 1'b0);
    bus.cmd = 2'b01; bus.payload = 8'h11; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_ss_low", 32'(bus.SS_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ss_n", 32'(bus.SS_n), 32'd1);
    check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("mid_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    armed = 1'b0;
    exp_rd_data = '0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("post_rst_rd_data", 32'(bus.rd_data), 32'(exp_rd_data));
    check("ram_unchanged", 32'(slave_ram[8'h3C]), 32'(exp_ram[8'h3C]));

    // Read-back after reset: armed was cleared, so seq_err must pulse.
    xfer(2'b11, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
